// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-side memory controller between the core's memory stage
// and a variable-latency data memory. It accepts one lw/sw at a time, turns it
// into a req/ready handshake, and stalls the core until the access finishes.
// A misaligned address or a memory that never answers ends the access with
// Error raised for the single DONE cycle.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [ADDR_WIDTH-1:0]     Addr,
  input  logic [DATA_WIDTH-1:0]     WriteData,
  output logic [DATA_WIDTH-1:0]     ReadData,
  output logic                      Stall,
  output logic                      Error,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready
);

  // Wide enough to hold TIMEOUT so the counter can never wrap.
  localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT                stateR;
  logic [CNT_WIDTH-1:0] counterR;
  logic                 requestS;
  logic                 misalignedS;
  logic                 unusedAddrBits;

  assign requestS    = MemRead | MemWrite;
  assign misalignedS = (Addr[1:0] != 2'b00);

  // Address bits above the memory's word range are deliberately dropped.
  assign unusedAddrBits = ^Addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

  // Stall decode: combinational in IDLE so the core freezes in the same cycle it asks.
  always_comb begin
    Stall = 1'b0;
    if (!rst_n) begin
      Stall = 1'b0;
    end else begin
      case (stateR)
        IDLE:    Stall = requestS;
        ACCESS:  Stall = 1'b1;
        DONE:    Stall = 1'b0;
        default: Stall = 1'b0;
      endcase
    end
  end

  // Access sequencer: captures the request, runs the handshake, and times out a silent memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= IDLE;
      counterR  <= {CNT_WIDTH{1'b0}};
      ReadData  <= {DATA_WIDTH{1'b0}};
      Error     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {MEM_ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_WIDTH{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          if (requestS) begin
            if (misalignedS) begin
              // Never touch memory with a misaligned word access.
              Error  <= 1'b1;
              stateR <= DONE;
            end else begin
              // A simultaneous read and write is issued as a write.
              mem_addr  <= Addr[MEM_ADDR_WIDTH+1:2];
              mem_we    <= MemWrite;
              mem_wdata <= WriteData;
              mem_req   <= 1'b1;
              counterR  <= {CNT_WIDTH{1'b0}};
              stateR    <= ACCESS;
            end
          end else begin
            stateR <= IDLE;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            // Completion wins over a timeout landing in the same cycle.
            mem_req <= 1'b0;
            if (!mem_we) begin
              ReadData <= mem_rdata;
            end else begin
              ReadData <= ReadData;
            end
            Error  <= 1'b0;
            stateR <= DONE;
          end else if (counterR == CNT_LAST) begin
            // The memory has had TIMEOUT cycles; abandon the access.
            mem_req <= 1'b0;
            if (!mem_we) begin
              ReadData <= {DATA_WIDTH{1'b0}};
            end else begin
              ReadData <= ReadData;
            end
            Error  <= 1'b1;
            stateR <= DONE;
          end else begin
            counterR <= counterR + CNT_ONE;
          end
        end

        DONE: begin
          // The core samples ReadData/Error now; any request still held is ignored.
          Error  <= 1'b0;
          stateR <= IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          Error   <= 1'b0;
          stateR  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized accesses against a reference model
// made of a word-array memory image, an expected ReadData value and the
// planned memory latency of each access.
module tb_data_mem_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Error;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] memModel [0:1023];
  logic [31:0] modelRd;

  data_mem_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_ADDR_WIDTH(10),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .Addr(Addr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .Stall(Stall),
    .Error(Error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".Stall"}, {31'd0, Stall}, 32'd0);
    check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, ".mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".ReadData"}, ReadData, 32'd0);
    check({tag, ".Error"}, {31'd0, Error}, 32'd0);
  endtask

  // k = cycles after mem_req rises until mem_ready (negative: never).
  // rstCycle = ACCESS cycle index at which reset is pulled (negative: never).
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k, input bit holdReq,
                          input int rstCycle, input string tag);
    bit         aligned;
    bit         timedOut;
    logic [9:0] wordAddr;
    aligned  = (addr % 4) == 0;
    wordAddr = 10'((addr / 4) % 1024);
    timedOut = 1'b1;

    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    Addr      = addr;
    WriteData = wdata;
    mem_ready = 1'b0;
    #1;
    check({tag, ".idleStall"}, {31'd0, Stall}, 32'd1);
    check({tag, ".idleReq"}, {31'd0, mem_req}, 32'd0);

    if (!aligned) begin
      @(negedge clk);
      check({tag, ".doneStall"}, {31'd0, Stall}, 32'd0);
      check({tag, ".doneReq"}, {31'd0, mem_req}, 32'd0);
      check({tag, ".doneError"}, {31'd0, Error}, 32'd1);
      check({tag, ".doneRd"}, ReadData, modelRd);
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        @(negedge clk);
        check({tag, ".accReq"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".accWe"}, {31'd0, mem_we}, {31'd0, wr});
        check({tag, ".accAddr"}, {22'd0, mem_addr}, {22'd0, wordAddr});
        check({tag, ".accWdata"}, mem_wdata, wdata);
        check({tag, ".accStall"}, {31'd0, Stall}, 32'd1);
        check({tag, ".accError"}, {31'd0, Error}, 32'd0);
        if (i == rstCycle) begin
          rst_n     = 1'b0;
          MemRead   = 1'b0;
          MemWrite  = 1'b0;
          mem_ready = 1'b0;
          #1;
          modelRd = 32'd0;
          checkResetValues({tag, ".rst"});
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        // The core may change its buses while stalled; the capture must hold.
        Addr      = $urandom;
        WriteData = $urandom;
        if (i == k) begin
          mem_ready = 1'b1;
          mem_rdata = memModel[wordAddr];
          timedOut  = 1'b0;
          break;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end

      @(negedge clk);
      // Ready here is outside ACCESS and must be ignored.
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (timedOut) begin
        if (!wr) modelRd = 32'd0;
      end else begin
        if (wr) memModel[wordAddr] = wdata;
        else    modelRd = memModel[wordAddr];
      end
      check({tag, ".doneStall"}, {31'd0, Stall}, 32'd0);
      check({tag, ".doneReq"}, {31'd0, mem_req}, 32'd0);
      check({tag, ".doneError"}, {31'd0, Error}, {31'd0, timedOut});
      check({tag, ".doneRd"}, ReadData, modelRd);
    end

    if (holdReq) begin
      @(negedge clk);
      mem_ready = 1'b0;
      check({tag, ".holdReq"}, {31'd0, mem_req}, 32'd0);
      check({tag, ".holdError"}, {31'd0, Error}, 32'd0);
      check({tag, ".holdRd"}, ReadData, modelRd);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      check({tag, ".holdStall"}, {31'd0, Stall}, 32'd0);
    end else begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int          k;
    int          kind;

    for (int i = 0; i < 1024; i++) memModel[i] = $urandom;
    modelRd   = 32'd0;
    rst_n     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Addr      = 32'd0;
    WriteData = 32'd0;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Aligned read answered in the first ACCESS cycle.
    memModel[4] = 32'hDEAD_BEEF;
    doAccess(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, -1, "rdK0");
    check("rdK0.value", ReadData, 32'hDEAD_BEEF);

    // Write answered after three wait cycles; ReadData must not move.
    doAccess(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 1'b0, -1, "wrK3");
    check("wrK3.mem", memModel[8], 32'h1234_5678);

    // Read that the memory never answers.
    doAccess(1'b1, 1'b0, 32'h0000_0030, 32'h0, -1, 1'b0, -1, "rdTimeout");

    // Misaligned read.
    doAccess(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 1'b0, -1, "misalign");

    // Read with a value first, then a write that times out keeps ReadData.
    doAccess(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, -1, "rdAgain");
    doAccess(1'b0, 1'b1, 32'h0000_0050, 32'hCAFE_F00D, -1, 1'b0, -1, "wrTimeout");

    // Ready on the very last allowed cycle beats the timeout.
    doAccess(1'b1, 1'b0, 32'h0000_0060, 32'h0, TIMEOUT - 1, 1'b0, -1, "rdLast");

    // Read and write together are a write; holding the request through DONE starts nothing.
    doAccess(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_0F0F, 1, 1'b1, -1, "rdwr");
    doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, -1, "rdBack");
    check("rdBack.value", ReadData, 32'hA5A5_0F0F);

    // mem_ready while idle is ignored.
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check("idleReady.Rd", ReadData, modelRd);
    check("idleReady.Req", {31'd0, mem_req}, 32'd0);
    check("idleReady.Error", {31'd0, Error}, 32'd0);

    // Reset in the second ACCESS cycle, then a normal read.
    doAccess(1'b1, 1'b0, 32'h0000_0070, 32'h0, -1, 1'b0, 1, "rstMid");
    doAccess(1'b1, 1'b0, 32'h0000_0074, 32'h0, 1, 1'b0, -1, "afterRst");

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      a    = $urandom;
      a    = (a & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) * 32'd4);
      kind = $urandom_range(0, 9);
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      wd = $urandom;
      k  = $urandom_range(0, TIMEOUT + 3);
      if (k >= TIMEOUT) k = -1;
      case ($urandom_range(0, 2))
        0:       doAccess(1'b1, 1'b0, a, wd, k, 1'($urandom_range(0, 1)), -1, "rnd");
        1:       doAccess(1'b0, 1'b1, a, wd, k, 1'($urandom_range(0, 1)), -1, "rnd");
        default: doAccess(1'b1, 1'b1, a, wd, k, 1'b0, -1, "rnd");
      endcase
    end

    @(negedge clk);
    check("final.Stall", {31'd0, Stall}, 32'd0);
    check("final.Rd", ReadData, modelRd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-side memory controller that services the load/store requests produced by the core's control path (MemRead for lw, MemWrite for sw) and converts them into a req/ready handshake to a variable-latency data memory. It sits between the core's execute/memory stage and the data memory, stalls the core while an access is outstanding, and returns load data and an error flag. One access is in flight at a time; there is no buffering beyond the captured request.

## Interface
- ADDR_WIDTH, 32, core byte-address width
- DATA_WIDTH, 32, data word width
- MEM_ADDR_WIDTH, 10, memory word-address width; mem_addr = Addr[MEM_ADDR_WIDTH+1:2]
- TIMEOUT, 15, max cycles waiting for mem_ready before aborting (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- MemRead  in  1  load request from core
- MemWrite  in  1  store request from core
- Addr  in  ADDR_WIDTH  byte address (ALU result)
- WriteData  in  DATA_WIDTH  store data
- ReadData  out  DATA_WIDTH  registered load data
- Stall  out  1  freeze core pipeline/PC while high
- Error  out  1  access aborted (misaligned or timeout); valid in DONE only
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MEM_ADDR_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ready
- mem_ready  in  1  memory completes access this cycle

## Operation
- States: IDLE, ACCESS, DONE. Reset → IDLE.
- Reset values: ReadData=0, Error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0; Stall=0 (IDLE, no request).
- IDLE: request = MemRead|MemWrite. Stall = request (combinational, same cycle). On request:
  - Addr[1:0]≠0 → DONE, Error=1, no memory access.
  - else capture mem_addr, mem_we=MemWrite, mem_wdata=WriteData; mem_req=1; counter=0; → ACCESS.
  - MemWrite and MemRead both high → treated as write.
- ACCESS: Stall=1; mem_req/mem_we/mem_addr/mem_wdata held stable. Each cycle:
  - mem_ready=1 → mem_req=0; if read, ReadData←mem_rdata; Error=0; → DONE.
  - else counter+1; counter reaches TIMEOUT-1 without ready → mem_req=0, Error=1, read returns ReadData=0; → DONE.
  - counter width $clog2(TIMEOUT+1), never wraps.
- DONE: Stall=0 (core retires instruction, samples ReadData/Error); request inputs ignored even if still high; → IDLE unconditionally; Error cleared on exit.
- ReadData holds its value until the next successful or timed-out read; writes do not change it.
- mem_ready outside ACCESS ignored.
- rst_n low in any state: immediate return to IDLE, mem_req drops asynchronously, in-flight access abandoned.

## Timing
- Request seen in IDLE cycle T; mem_req high from T+1.
- Memory asserting mem_ready k cycles after mem_req rises (k=0 = same first ACCESS cycle): DONE at T+2+k; Stall high cycles T..T+1+k (k+2 cycles).
- Timeout: mem_req high exactly TIMEOUT cycles, DONE at T+1+TIMEOUT.
- Misaligned: Stall high one cycle (T), DONE at T+1, mem_req never asserted.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, ACCESS, DONE).

## Test plan
- Aligned read Addr=0x0000_0010, memory ready k=0 with mem_rdata=0xDEADBEEF → mem_addr=4, mem_we=0, Stall 2 cycles, ReadData=0xDEADBEEF and Error=0 in DONE.
- Write Addr=0x0000_0020, WriteData=0x12345678, ready after k=3 → mem_req held 4 cycles with mem_we=1, mem_addr=8, mem_wdata=0x12345678 stable; ReadData unchanged; Stall 5 cycles.
- Read with mem_ready never asserted, TIMEOUT=15 → mem_req high 15 cycles, Error=1 and ReadData=0 in DONE, then IDLE.
- MemRead=1, Addr=0x0000_0013 → mem_req never rises, Stall 1 cycle, Error=1 next cycle.
- MemRead=MemWrite=1, Addr=0x40 → mem_we=1 write issued; MemRead held high through DONE causes no second access.
- rst_n pulled low in ACCESS cycle 2 → mem_req=0, Stall=0, all outputs at reset values immediately; after release, new read completes normally.
